// File: rtl/regfile_scan_reader_pkg.sv
// Shared types and width helpers for the register-file scan reader.
package regfile_scan_reader_pkg;

    // Sweep controller states.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StSend  = 2'd2,
        StDone  = 2'd3
    } scan_state_e;

    // Running-sum width: depth * max entry fits in DW+AW bits.
    function automatic int unsigned sum_width(input int unsigned aw, input int unsigned dw);
        return aw + dw;
    endfunction

endpackage

// File: rtl/regfile_scan_reader.sv
// Sweeps a wrap-around range of a combinational-read register file and emits each
// entry as one valid/ready beat, accumulating the sum of accepted beats.
module regfile_scan_reader
    import regfile_scan_reader_pkg::*;
#(
    parameter int unsigned AW = 3,
    parameter int unsigned DW = 4,
    localparam int unsigned SW = sum_width(AW, DW)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   len,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_index,
    output logic          out_last,
    output logic [SW-1:0] sum,
    output logic          busy,
    output logic          done
);

    scan_state_e   state_q, state_d;
    logic [AW-1:0] ptr_q;
    logic [AW:0]   rem_q;
    logic [DW-1:0] data_q;
    logic [AW-1:0] index_q;
    logic          last_q;
    logic [SW-1:0] sum_q;

    logic load;     // accepted start command
    logic capture;  // read the entry at ptr into the output beat and advance
    logic accept;   // output beat handshake

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = (len == '0) ? StDone : StFetch;
            StFetch: state_d = StSend;
            StSend:  if (out_ready && last_q) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Decoded outputs and datapath controls.
    always_comb begin
        out_valid = (state_q == StSend);
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        load      = (state_q == StIdle) && start;
        accept    = (state_q == StSend) && out_ready;
        // Back-to-back capture on a non-final handshake keeps one beat per cycle.
        capture   = (state_q == StFetch) || (accept && !last_q);
    end

    // Pointer, remaining count, captured beat and running sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            index_q <= '0;
            last_q  <= 1'b0;
            sum_q   <= '0;
        end else begin
            if (load) begin
                ptr_q <= base;
                rem_q <= len;
                sum_q <= '0;
            end
            if (accept) begin
                sum_q <= sum_q + SW'(data_q);
            end
            if (capture) begin
                data_q  <= rd_data;
                index_q <= ptr_q;
                last_q  <= (rem_q == (AW+1)'(1));
                ptr_q   <= ptr_q + 1'b1;
                rem_q   <= rem_q - 1'b1;
            end
        end
    end

    assign rd_addr   = ptr_q;
    assign out_data  = data_q;
    assign out_index = index_q;
    assign out_last  = last_q;
    assign sum       = sum_q;

endmodule
